dport_sram: RTL and testbench

Data-port tightly coupled memory slave that sits directly downstream of the core's data port (`dreq*`/`drsp*`). It accepts load/store requests, performs byte/half/word accesses on a single-port synchronous SRAM array, and checks each request for range, alignment and privilege errors. Every request gets exactly one in-order response, queued so the core can apply `drspready` backpressure. Sustained throughput is one request per cycle.

---
 rtl/dport_sram_pkg.sv | 36 +++
 rtl/dport_sram_array.sv | 30 +++
 rtl/dport_sram.sv | 131 +++++++++++++
 tb/tb_dport_sram.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dport_sram_pkg.sv
// Shared types, encodings and lane helpers for the data-port TCM slave.
// Imported by dport_sram and dport_sram_array.
package dport_sram_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] DREQ_SIZE_B = 2'd0;
    localparam logic [1:0] DREQ_SIZE_H = 2'd1;
    localparam logic [1:0] DREQ_SIZE_W = 2'd2;
    localparam logic [1:0] HPL_USER    = 2'b00;

    typedef struct packed {
        logic              rerr;
        logic              werr;
        logic [DATA_W-1:0] data;
    } rsp_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            DREQ_SIZE_B: byte_en = 4'b0001 << off;
            DREQ_SIZE_H: byte_en = 4'b0011 << off;
            DREQ_SIZE_W: byte_en = 4'b1111;
            default:     byte_en = 4'b0000;
        endcase
    endfunction

    // Right-justified store data replicated so every enabled lane sees its byte.
    function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size, input logic [DATA_W-1:0] d);
        case (size)
            DREQ_SIZE_B: lane_data = {4{d[7:0]}};
            DREQ_SIZE_H: lane_data = {2{d[15:0]}};
            default:     lane_data = d;
        endcase
    endfunction

endpackage

// File: rtl/dport_sram_array.sv
// Single-port 32-bit synchronous RAM with byte write enables and 1-cycle read.
// Contents are deliberately never reset so the array infers as block RAM.
module dport_sram_array
    import dport_sram_pkg::*;
#(
    parameter int C_MEM_DEPTH_X = 12
) (
    input  logic                     i_clk,
    input  logic                     i_en,
    input  logic [3:0]               i_we,
    input  logic [C_MEM_DEPTH_X-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<C_MEM_DEPTH_X)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dport_sram.sv
// Data-port TCM slave: checks and performs byte/half/word accesses on the array
// and returns one in-order response per request through a 2-entry queue.
module dport_sram
    import dport_sram_pkg::*;
#(
    parameter int          C_MEM_DEPTH_X = 12,
    parameter logic [31:0] C_PROT_LIMIT  = 32'h400
) (
    input  logic        clk_i,
    input  logic        clk_en_i,
    input  logic        reset_i,
    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic [1:0]  dreqsize_i,
    input  logic        dreqdvalid_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic [31:0] dreqdata_i,
    input  logic        drspready_i,
    output logic        drspvalid_o,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o
);

    logic [1:0]        r_outst;
    logic              r_s1_vld;
    logic              r_s1_rerr;
    logic              r_s1_werr;
    logic              r_s1_load;
    logic [1:0]        r_qcnt;
    rsp_t              r_q0;
    rsp_t              r_q1;

    logic              w_acc;
    logic              w_err;
    logic              w_ram_en;
    logic [3:0]        w_we;
    logic [DATA_W-1:0] w_rdata;
    rsp_t              w_s1;
    rsp_t              w_head;
    logic              w_out_vld;
    logic              w_hs;
    logic              w_pop;
    logic              w_push;
    rsp_t              w_q0_n;
    rsp_t              w_q1_n;
    logic [1:0]        w_qcnt_n;

    // Ready depends only on registered occupancy, never on drspready_i.
    assign dreqready_o = clk_en_i & ~reset_i & (r_outst < 2'd2);
    assign w_acc       = dreqvalid_i & dreqready_o;

    assign w_err = (dreqsize_i == 2'd3)
                 | ((dreqsize_i == DREQ_SIZE_H) & dreqaddr_i[0])
                 | ((dreqsize_i == DREQ_SIZE_W) & (dreqaddr_i[1:0] != 2'b00))
                 | (|dreqaddr_i[31:C_MEM_DEPTH_X+2])
                 | (dreqdvalid_i & (dreqhpl_i == HPL_USER) & (dreqaddr_i < C_PROT_LIMIT));

    assign w_ram_en = w_acc & ~w_err;
    assign w_we     = (w_ram_en & dreqdvalid_i) ? byte_en(dreqsize_i, dreqaddr_i[1:0]) : 4'b0000;

    dport_sram_array #(
        .C_MEM_DEPTH_X (C_MEM_DEPTH_X)
    ) u_array (
        .i_clk   (clk_i),
        .i_en    (w_ram_en),
        .i_we    (w_we),
        .i_addr  (dreqaddr_i[C_MEM_DEPTH_X+1:2]),
        .i_wdata (lane_data(dreqsize_i, dreqdata_i)),
        .o_rdata (w_rdata)
    );

    // S1: result of the access performed on the accept edge
    always_ff @(posedge clk_i) begin
        if (w_acc) begin
            r_s1_rerr <= w_err & ~dreqdvalid_i;
            r_s1_werr <= w_err & dreqdvalid_i;
            r_s1_load <= ~w_err & ~dreqdvalid_i;
        end
    end

    assign w_s1      = '{rerr: r_s1_rerr, werr: r_s1_werr, data: r_s1_load ? w_rdata : '0};
    assign w_out_vld = (r_qcnt != 2'd0) | r_s1_vld;
    assign w_head    = (r_qcnt != 2'd0) ? r_q0 : w_s1;
    assign w_hs      = w_out_vld & drspready_i & clk_en_i;

    assign drspvalid_o = w_out_vld;
    assign drsprerr_o  = w_out_vld & w_head.rerr;
    assign drspwerr_o  = w_out_vld & w_head.werr;
    assign drspdata_o  = w_out_vld ? w_head.data : '0;

    // S1 drains every enabled cycle: either handed off directly or queued
    assign w_pop  = w_hs & (r_qcnt != 2'd0);
    assign w_push = r_s1_vld & ~((r_qcnt == 2'd0) & w_hs);

    always_comb begin
        w_q0_n   = r_q0;
        w_q1_n   = r_q1;
        w_qcnt_n = r_qcnt;
        if (w_pop) begin
            w_q0_n   = r_q1;
            w_qcnt_n = r_qcnt - 2'd1;
        end
        if (w_push) begin
            if (w_qcnt_n == 2'd0) w_q0_n = w_s1;
            else                  w_q1_n = w_s1;
            w_qcnt_n = w_qcnt_n + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_outst  <= 2'd0;
            r_s1_vld <= 1'b0;
            r_qcnt   <= 2'd0;
        end else if (clk_en_i) begin
            r_outst  <= r_outst + {1'b0, w_acc} - {1'b0, w_hs};
            r_s1_vld <= w_acc;
            r_qcnt   <= w_qcnt_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            r_q0 <= w_q0_n;
            r_q1 <= w_q1_n;
        end
    end

endmodule

// File: tb/tb_dport_sram.sv
// Self-checking bench for dport_sram: byte-level memory model with an expected
// response queue checked every cycle, plus directed literal checks.
module tb_dport_sram;

    localparam int          X         = 12;
    localparam logic [31:0] PROT      = 32'h400;
    localparam logic [31:0] MEM_BYTES = 32'h1 << (X + 2);

    logic        clk_i = 1'b0;
    logic        clk_en_i;
    logic        reset_i;
    logic        dreqready_o;
    logic        dreqvalid_i;
    logic [1:0]  dreqsize_i;
    logic        dreqdvalid_i;
    logic [1:0]  dreqhpl_i;
    logic [31:0] dreqaddr_i;
    logic [31:0] dreqdata_i;
    logic        drspready_i;
    logic        drspvalid_o;
    logic        drsprerr_o;
    logic        drspwerr_o;
    logic [31:0] drspdata_o;

    dport_sram #(.C_MEM_DEPTH_X(X), .C_PROT_LIMIT(PROT)) dut (
        .clk_i        (clk_i),
        .clk_en_i     (clk_en_i),
        .reset_i      (reset_i),
        .dreqready_o  (dreqready_o),
        .dreqvalid_i  (dreqvalid_i),
        .dreqsize_i   (dreqsize_i),
        .dreqdvalid_i (dreqdvalid_i),
        .dreqhpl_i    (dreqhpl_i),
        .dreqaddr_i   (dreqaddr_i),
        .dreqdata_i   (dreqdata_i),
        .drspready_i  (drspready_i),
        .drspvalid_o  (drspvalid_o),
        .drsprerr_o   (drsprerr_o),
        .drspwerr_o   (drspwerr_o),
        .drspdata_o   (drspdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rerr;
        logic        werr;
        logic        known;
        logic [31:0] data;
        int          acc_cyc;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mem_b[int];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         n_pop = 0;
    bit         mon_en = 0;
    bit         lat_chk = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour of one accepted request, expressed on a byte-addressed memory
    task automatic model_accept(input logic [1:0] sz, input logic st, input logic [1:0] hpl,
                                input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   bad;
        int   w;
        int   nb;
        int   off;
        bad = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0) ||
              (a >= MEM_BYTES) || (st && hpl == 0 && a < PROT);
        e.rerr    = bad && !st;
        e.werr    = bad && st;
        e.known   = 1'b1;
        e.data    = 32'h0;
        e.acc_cyc = cyc;
        if (!bad) begin
            w   = int'(a >> 2);
            nb  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
            off = int'(a[1:0]);
            if (st) begin
                for (int k = 0; k < nb; k++) mem_b[w*4 + off + k] = d[8*k +: 8];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_b.exists(w*4 + b)) e.data[8*b +: 8] = mem_b[w*4 + b];
                    else e.known = 1'b0;
                end
            end
        end
        expq.push_back(e);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("ready", 32'(dreqready_o),
                32'(clk_en_i && !reset_i && expq.size() < 2));
            if (expq.size() > 0) begin
                chk("rsp_valid", 32'(drspvalid_o), 32'd1);
                chk("rsp_rerr", 32'(drsprerr_o), 32'(expq[0].rerr));
                chk("rsp_werr", 32'(drspwerr_o), 32'(expq[0].werr));
                if (expq[0].known) chk("rsp_data", drspdata_o, expq[0].data);
            end else begin
                chk("rsp_idle", 32'(drspvalid_o), 32'd0);
            end
            if (reset_i) begin
                expq.delete();
            end else if (clk_en_i) begin
                if (expq.size() > 0 && drspready_i) begin
                    if (lat_chk) chk("latency", cyc, expq[0].acc_cyc + 1);
                    void'(expq.pop_front());
                    n_pop++;
                end
                if (dreqvalid_i && dreqready_o)
                    model_accept(dreqsize_i, dreqdvalid_i, dreqhpl_i, dreqaddr_i, dreqdata_i);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] sz, input logic st, input logic [1:0] hpl,
                         input logic [31:0] a, input logic [31:0] d);
        dreqvalid_i  = 1'b1;
        dreqsize_i   = sz;
        dreqdvalid_i = st;
        dreqhpl_i    = hpl;
        dreqaddr_i   = a;
        dreqdata_i   = d;
    endtask

    // One request with drspready_i high; response must appear the cycle after accept
    task automatic single(input logic [1:0] sz, input logic st, input logic [1:0] hpl,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic er, input logic ew, input logic [31:0] ed, input string nm);
        bit acc;
        int t;
        acc = 0;
        t   = 0;
        drive(sz, st, hpl, a, d);
        while (!acc && t < 20) begin
            @(negedge clk_i);
            acc = dreqready_o;
            step();
            t++;
        end
        dreqvalid_i = 1'b0;
        chk({nm, "_acc"}, 32'(acc), 32'd1);
        @(negedge clk_i);
        chk({nm, "_vld"}, 32'(drspvalid_o), 32'd1);
        chk({nm, "_rerr"}, 32'(drsprerr_o), 32'(er));
        chk({nm, "_werr"}, 32'(drspwerr_o), 32'(ew));
        chk({nm, "_data"}, drspdata_o, ed);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int t;
        int c;
        logic [34:0] snap;

        clk_en_i     = 1'b1;
        reset_i      = 1'b1;
        dreqvalid_i  = 1'b0;
        dreqsize_i   = 2'd0;
        dreqdvalid_i = 1'b0;
        dreqhpl_i    = 2'd0;
        dreqaddr_i   = 32'h0;
        dreqdata_i   = 32'h0;
        drspready_i  = 1'b1;
        repeat (3) step();

        chk("rst_ready", 32'(dreqready_o), 32'd0);
        chk("rst_valid", 32'(drspvalid_o), 32'd0);
        chk("rst_rerr", 32'(drsprerr_o), 32'd0);
        chk("rst_werr", 32'(drspwerr_o), 32'd0);
        chk("rst_data", drspdata_o, 32'h0);
        reset_i = 1'b0;
        #1;
        chk("rst_release_ready", 32'(dreqready_o), 32'd1);
        mon_en = 1'b1;
        step();

        // Word store / load
        single(2'd2, 1, 2'd3, 32'h1000, 32'hDEADBEEF, 0, 0, 32'h0, "st_word");
        single(2'd2, 0, 2'd3, 32'h1000, 32'h0, 0, 0, 32'hDEADBEEF, "ld_word");

        // Byte / half lanes
        single(2'd0, 1, 2'd3, 32'h1003, 32'h000000AA, 0, 0, 32'h0, "st_byte");
        single(2'd1, 1, 2'd3, 32'h1000, 32'h00001234, 0, 0, 32'h0, "st_half");
        single(2'd2, 0, 2'd3, 32'h1000, 32'h0, 0, 0, 32'hAAAD1234, "ld_lanes");

        // Error cases
        single(2'd1, 0, 2'd3, 32'h1001, 32'h0, 1, 0, 32'h0, "ld_misalign");
        single(2'd2, 0, 2'd3, MEM_BYTES, 32'h0, 1, 0, 32'h0, "ld_range");
        single(2'd3, 0, 2'd3, 32'h1000, 32'h0, 1, 0, 32'h0, "ld_size3");
        single(2'd2, 1, 2'd3, 32'h1002, 32'h1, 0, 1, 32'h0, "st_misalign");
        single(2'd2, 1, 2'd3, MEM_BYTES + 32'h4, 32'h1, 0, 1, 32'h0, "st_range");
        single(2'd2, 1, 2'd3, 32'h0010, 32'h55667788, 0, 0, 32'h0, "st_prot_init");
        single(2'd2, 1, 2'd0, 32'h0010, 32'h11111111, 0, 1, 32'h0, "st_prot_user");
        single(2'd2, 0, 2'd0, 32'h0010, 32'h0, 0, 0, 32'h55667788, "ld_prot_keep");
        single(2'd2, 1, 2'd3, 32'h0010, 32'h99AABBCC, 0, 0, 32'h0, "st_prot_mach");
        single(2'd2, 0, 2'd0, 32'h0010, 32'h0, 0, 0, 32'h99AABBCC, "ld_prot_new");
        single(2'd2, 1, 2'd0, PROT, 32'h0BADF00D, 0, 0, 32'h0, "st_user_limit");

        // Backpressure: 4 loads with the response side stalled
        drspready_i = 1'b0;
        acc = 0;
        drive(2'd2, 0, 2'd3, 32'h1000, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (dreqready_o) acc++;
            step();
            dreqaddr_i = acc[0] ? 32'h0010 : 32'h1000;
        end
        chk("bp_accepts_stalled", acc, 2);
        chk("bp_ready_low", 32'(dreqready_o), 32'd0);
        drspready_i = 1'b1;
        t = 0;
        while (acc < 4 && t < 20) begin
            @(negedge clk_i);
            if (dreqready_o) acc++;
            step();
            t++;
            dreqaddr_i = acc[0] ? 32'h0010 : 32'h1000;
        end
        dreqvalid_i = 1'b0;
        chk("bp_accepts_total", acc, 4);
        repeat (4) step();

        // Throughput: 16 back-to-back stores then 16 back-to-back loads
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            drive(2'd2, 1, 2'd3, 32'h2000 + 32'(4*i), 32'hC0DE0000 + 32'(i));
            @(negedge clk_i);
            if (dreqready_o) acc++;
            step();
        end
        dreqvalid_i = 1'b0;
        chk("tp_store_accepts", acc, 16);
        repeat (3) step();
        acc = 0;
        n_pop = 0;
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(2'd2, 0, 2'd3, 32'h2000 + 32'(4*i), 32'h0);
            @(negedge clk_i);
            if (dreqready_o) acc++;
            step();
        end
        dreqvalid_i = 1'b0;
        repeat (3) step();
        lat_chk = 1'b0;
        chk("tp_load_accepts", acc, 16);
        chk("tp_load_responses", n_pop, 16);

        // Reset with two responses pending
        drspready_i = 1'b0;
        acc = 0;
        t = 0;
        drive(2'd2, 0, 2'd3, 32'h1000, 32'h0);
        while (acc < 2 && t < 10) begin
            @(negedge clk_i);
            if (dreqready_o) acc++;
            step();
            t++;
        end
        dreqvalid_i = 1'b0;
        chk("rstmid_pending", acc, 2);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        #1;
        chk("rstmid_valid", 32'(drspvalid_o), 32'd0);
        chk("rstmid_rerr", 32'(drsprerr_o), 32'd0);
        chk("rstmid_werr", 32'(drspwerr_o), 32'd0);
        chk("rstmid_data", drspdata_o, 32'h0);
        chk("rstmid_ready", 32'(dreqready_o), 32'd1);
        drspready_i = 1'b1;
        step();
        single(2'd2, 0, 2'd3, 32'h1000, 32'h0, 0, 0, 32'hAAAD1234, "ld_after_rst");

        // Clock enable dropped for 3 cycles in the middle of a load stream
        acc = 0;
        c = 0;
        snap = '0;
        while (c < 30 && acc < 8) begin
            clk_en_i = !(c >= 3 && c < 6);
            drive(2'd2, 0, 2'd3, 32'h2000 + 32'(4*acc), 32'h0);
            @(negedge clk_i);
            if (c == 3) snap = {drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o};
            if (c > 3 && c < 6)
                chk("ce_hold", snap[31:0], drspdata_o);
            if (c == 5) begin
                chk("ce_hold_valid", 32'(snap[34]), 32'(drspvalid_o));
                chk("ce_ready_low", 32'(dreqready_o), 32'd0);
            end
            if (dreqready_o) acc++;
            step();
            c++;
        end
        clk_en_i = 1'b1;
        dreqvalid_i = 1'b0;
        chk("ce_accepts", acc, 8);
        chk("ce_cycles", c, 11);
        chk("ce_snap_valid", 32'(snap[34]), 32'd1);
        chk("ce_snap_data", snap[31:0], 32'hC0DE0002);

        repeat (4) step();
        chk("drain", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
